// File: rtl/counter_bank.sv
// counter_bank: multi-channel loadable wrap/saturate counters with registered read-back; define COUNTER_BANK_SNAP_EN for snapshot reads
module counter_bank #(
  parameter int NUM_CH = 4,
  parameter int WIDTH = 32,
  parameter int CH_AW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic [NUM_CH-1:0] mode,
  input  logic              cfg_wr,
  input  logic              cfg_sel,
  input  logic [CH_AW-1:0]  cfg_ch,
  input  logic [WIDTH-1:0]  cfg_data,
  input  logic              rd_en,
  input  logic [CH_AW-1:0]  rd_ch,
`ifdef COUNTER_BANK_SNAP_EN
  input  logic              snap,
`endif
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_vld,
  output logic [NUM_CH-1:0] tc_pulse,
  output logic [NUM_CH-1:0] sat,
  output logic [WIDTH-1:0]  cnt_or
);
  logic [WIDTH-1:0] cnt [NUM_CH];
  logic [WIDTH-1:0] lim [NUM_CH];
`ifdef COUNTER_BANK_SNAP_EN
  logic [WIDTH-1:0] shd [NUM_CH];
`endif
  logic [WIDTH-1:0] rd_val;
  logic [WIDTH-1:0] or_all;
  logic [NUM_CH-1:0] wr_hit;
  always_comb begin
    rd_val = '0;
    or_all = '0;
    wr_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i] = cfg_wr && cfg_ch == CH_AW'(i);
      or_all = or_all | cnt[i];
`ifdef COUNTER_BANK_SNAP_EN
      rd_val = rd_ch == CH_AW'(i) ? shd[i] : rd_val;
`else
      rd_val = rd_ch == CH_AW'(i) ? cnt[i] : rd_val;
`endif
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i] <= '0;
        lim[i] <= '1;
`ifdef COUNTER_BANK_SNAP_EN
        shd[i] <= '0;
`endif
      end
      sat <= '0;
      tc_pulse <= '0;
      rd_data <= '0;
      rd_vld <= 1'b0;
      cnt_or <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        tc_pulse[i] <= 1'b0;
`ifdef COUNTER_BANK_SNAP_EN
        if (snap) shd[i] <= cnt[i];
`endif
        if (wr_hit[i]) begin
          if (cfg_sel) lim[i] <= cfg_data;
          else cnt[i] <= cfg_data;
          sat[i] <= 1'b0;
        end else if (clken && ch_en[i]) begin
          if (cnt[i] != lim[i]) cnt[i] <= cnt[i] + WIDTH'(1);
          else if (!mode[i]) begin
            cnt[i] <= '0;
            tc_pulse[i] <= 1'b1;
          end else if (!sat[i]) begin
            sat[i] <= 1'b1;
            tc_pulse[i] <= 1'b1;
          end
        end
      end
      rd_vld <= rd_en;
      rd_data <= rd_en ? rd_val : '0;
      cnt_or <= or_all;
    end
  end
endmodule
